// File: rtl/nec_operand_fetch_if.sv
// nec_operand_fetch_if: decoder <-> operand-fetch bus (queue view, sizes, results).
// Rev 1.0
`default_nettype none

interface nec_operand_fetch_if #(
   parameter int QUEUE_DEPTH = 8
);
   localparam int LW = $clog2(QUEUE_DEPTH) + 1;

   logic                        ce;
   logic                        set_pc;
   logic [15:0]                 new_pc;
   logic                        start;
   logic [2:0]                  disp_size;
   logic [2:0]                  imm_size;
   logic                        imm_sext;
   logic [LW-1:0]               ipq_len;
   logic [QUEUE_DEPTH-1:0][7:0] ipq;
   logic                        retire;

   logic [15:0]                 pc;
   logic [2:0]                  consumed;
   logic                        busy;
   logic                        valid;
   logic [15:0]                 disp;
   logic [31:0]                 imm;
   logic [15:0]                 end_pc;
   logic                        size_err;

   modport master (
      output ce, set_pc, new_pc, start, disp_size, imm_size, imm_sext,
             ipq_len, ipq, retire,
      input  pc, consumed, busy, valid, disp, imm, end_pc, size_err
   );

   modport slave (
      input  ce, set_pc, new_pc, start, disp_size, imm_size, imm_sext,
             ipq_len, ipq, retire,
      output pc, consumed, busy, valid, disp, imm, end_pc, size_err
   );
endinterface

`default_nettype wire

// File: rtl/nec_operand_fetch.sv
// nec_operand_fetch: pulls displacement/immediate bytes out of the prefetch queue.
// Rev 1.0
`default_nettype none

module nec_operand_fetch #(
   parameter int QUEUE_DEPTH     = 8,
   parameter int MAX_DISP        = 2,
   parameter int MAX_IMM         = 4,
   parameter int BYTES_PER_CYCLE = 1
) (
   input  logic               clk,
   input  logic               reset,
   nec_operand_fetch_if.slave bus
);
   localparam int         AW         = $clog2(QUEUE_DEPTH);
   localparam logic [2:0] MAX_DISP_C = 3'(MAX_DISP);
   localparam logic [2:0] MAX_IMM_C  = 3'(MAX_IMM);
   localparam logic [4:0] BPC_C      = 5'(BYTES_PER_CYCLE);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [15:0]   pc_q, pc_d;
   logic [15:0]   end_pc_q, end_pc_d;
   logic [15:0]   disp_q, disp_d;
   logic [31:0]   imm_q, imm_d;
   logic [2:0]    dsz_q, dsz_d;
   logic [2:0]    isz_q, isz_d;
   logic [2:0]    drem_q, drem_d;
   logic [2:0]    irem_q, irem_d;
   logic          sext_q, sext_d;
   logic          err_q, err_d;

   logic [4:0]    n;
   logic [4:0]    qlen;
   logic [4:0]    rem_total;
   logic [4:0]    done_total;
   logic [4:0]    to_disp;
   logic [4:0]    pos;
   logic [7:0]    byte_v;
   logic [AW-1:0] slot;
   logic          size_bad;
   logic          accept_start;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      end_pc_d = end_pc_q;
      disp_d   = disp_q;
      imm_d    = imm_q;
      dsz_d    = dsz_q;
      isz_d    = isz_q;
      drem_d   = drem_q;
      irem_d   = irem_q;
      sext_d   = sext_q;
      err_d    = err_q;
      n        = '0;
      to_disp  = '0;
      pos      = '0;
      byte_v   = '0;
      slot     = '0;

      qlen         = 5'(bus.ipq_len);
      rem_total    = 5'(drem_q) + 5'(irem_q);
      done_total   = 5'(dsz_q) + 5'(isz_q) - rem_total;
      size_bad     = (bus.disp_size > MAX_DISP_C) || (bus.imm_size > MAX_IMM_C);
      accept_start = bus.start &&
                     ((state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.retire));

      if (bus.set_pc) begin
         pc_d     = bus.new_pc;
         end_pc_d = bus.new_pc;
         state_d  = ST_IDLE;
         disp_d   = '0;
         imm_d    = '0;
         drem_d   = '0;
         irem_d   = '0;
      end else if (bus.ce) begin
         case (state_q)
            ST_FETCH: begin
               n = BPC_C;
               if (rem_total < n) n = rem_total;
               if (qlen < n)      n = qlen;

               // Bytes land by their position in the combined disp+imm stream.
               for (int k = 0; k < BYTES_PER_CYCLE; k++) begin
                  if (5'(k) < n) begin
                     slot   = pc_q[AW-1:0] + AW'(k);
                     byte_v = bus.ipq[slot];
                     pos    = done_total + 5'(k);
                     if (pos < 5'(dsz_q)) begin
                        for (int j = 0; j < MAX_DISP; j++) begin
                           if (pos == 5'(j)) disp_d[8*j +: 8] = byte_v;
                        end
                     end else begin
                        for (int j = 0; j < MAX_IMM; j++) begin
                           if ((pos - 5'(dsz_q)) == 5'(j)) imm_d[8*j +: 8] = byte_v;
                        end
                     end
                  end
               end

               to_disp  = (n < 5'(drem_q)) ? n : 5'(drem_q);
               drem_d   = drem_q - 3'(to_disp);
               irem_d   = irem_q - 3'(n - to_disp);
               pc_d     = pc_q + 16'(n);
               end_pc_d = pc_q + 16'(n);

               if ((n != 5'd0) && (n == rem_total)) begin
                  state_d = ST_DONE;
                  if (sext_q && (isz_q == 3'd1)) imm_d[31:8] = {24{imm_d[7]}};
               end
            end
            ST_DONE: begin
               if (bus.retire) state_d = ST_IDLE;
            end
            default: ;
         endcase

         // A start accepted from DONE overrides the retire-to-IDLE above.
         if (accept_start) begin
            if (size_bad) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               dsz_d    = bus.disp_size;
               isz_d    = bus.imm_size;
               drem_d   = bus.disp_size;
               irem_d   = bus.imm_size;
               sext_d   = bus.imm_sext;
               disp_d   = '0;
               imm_d    = '0;
               end_pc_d = pc_q;
               state_d  = ((bus.disp_size == 3'd0) && (bus.imm_size == 3'd0)) ?
                          ST_DONE : ST_FETCH;
            end
         end
      end

      bus.consumed = reset ? 3'd0 : 3'(n);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         pc_q     <= '0;
         end_pc_q <= '0;
         disp_q   <= '0;
         imm_q    <= '0;
         dsz_q    <= '0;
         isz_q    <= '0;
         drem_q   <= '0;
         irem_q   <= '0;
         sext_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         end_pc_q <= end_pc_d;
         disp_q   <= disp_d;
         imm_q    <= imm_d;
         dsz_q    <= dsz_d;
         isz_q    <= isz_d;
         drem_q   <= drem_d;
         irem_q   <= irem_d;
         sext_q   <= sext_d;
         err_q    <= err_d;
      end
   end

   assign bus.pc       = pc_q;
   assign bus.end_pc   = end_pc_q;
   assign bus.disp     = disp_q;
   assign bus.imm      = imm_q;
   assign bus.busy     = (state_q == ST_FETCH);
   assign bus.valid    = (state_q == ST_DONE) && !bus.set_pc;
   assign bus.size_err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_nec_operand_fetch.sv
// tb_nec_operand_fetch: two instances (1 and 6 bytes/cycle) against a byte-memory reference.
// Rev 1.0
`default_nettype none

module tb_nec_operand_fetch;
   localparam int QD = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        ce, set_pc, start, imm_sext, retire;
   logic [15:0] new_pc;
   logic [2:0]  disp_size, imm_size;
   logic [3:0]  qlen;
   logic [7:0]  mem [65536];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   nec_operand_fetch_if #(.QUEUE_DEPTH(QD)) if1 ();
   nec_operand_fetch_if #(.QUEUE_DEPTH(QD)) if6 ();

   nec_operand_fetch #(.QUEUE_DEPTH(QD), .MAX_DISP(2), .MAX_IMM(4), .BYTES_PER_CYCLE(1))
      u_dut1 (.clk(clk), .reset(reset), .bus(if1));
   nec_operand_fetch #(.QUEUE_DEPTH(QD), .MAX_DISP(2), .MAX_IMM(4), .BYTES_PER_CYCLE(6))
      u_dut6 (.clk(clk), .reset(reset), .bus(if6));

   assign if1.ce = ce;             assign if6.ce = ce;
   assign if1.set_pc = set_pc;     assign if6.set_pc = set_pc;
   assign if1.new_pc = new_pc;     assign if6.new_pc = new_pc;
   assign if1.start = start;       assign if6.start = start;
   assign if1.disp_size = disp_size; assign if6.disp_size = disp_size;
   assign if1.imm_size = imm_size; assign if6.imm_size = imm_size;
   assign if1.imm_sext = imm_sext; assign if6.imm_sext = imm_sext;
   assign if1.ipq_len = qlen;      assign if6.ipq_len = qlen;
   assign if1.retire = retire;     assign if6.retire = retire;

   typedef struct {
      logic [15:0] pc0;
      logic [2:0]  d;
      logic [2:0]  i;
      logic        sx;
      logic [47:0] bytes;
      logic [15:0] edisp;
      logic [31:0] eimm;
      logic [15:0] eend;
      int          lat1;
      int          lat6;
   } vec_t;

   vec_t tbl [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Queue slot s holds the memory byte at the address within [pc, pc+QD) that maps to s.
   task automatic refresh();
      logic [2:0] off;
      for (int k = 0; k < QD; k++) begin
         off = 3'(k) - if1.pc[2:0];
         if1.ipq[k] = mem[if1.pc + 16'(off)];
         off = 3'(k) - if6.pc[2:0];
         if6.ipq[k] = mem[if6.pc + 16'(off)];
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      refresh();
   endtask

   function automatic logic [15:0] ref_disp(input logic [15:0] p, input int d);
      logic [15:0] r;
      r = '0;
      for (int j = 0; j < d; j++) r = r | (16'(mem[p + 16'(j)]) << (8 * j));
      return r;
   endfunction

   function automatic logic [31:0] ref_imm(input logic [15:0] p, input int d, input int i,
                                           input logic sx);
      logic [31:0] r;
      r = '0;
      for (int j = 0; j < i; j++) r = r | (32'(mem[p + 16'(d + j)]) << (8 * j));
      if (sx && (i == 1) && r[7]) r = r | 32'hFFFF_FF00;
      return r;
   endfunction

   function automatic int min3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b < m) m = b;
      if (c < m) m = c;
      return m;
   endfunction

   task automatic load_pc(input logic [15:0] p);
      set_pc = 1'b1; new_pc = p; start = 1'b0; retire = 1'b0; ce = 1'b0;
      cyc();
      set_pc = 1'b0;
   endtask

   task automatic start_txn(input logic [2:0] d, input logic [2:0] i, input logic sx);
      disp_size = d; imm_size = i; imm_sext = sx;
      start = 1'b1; ce = 1'b1; qlen = 4'(QD);
      refresh();
      cyc();
      start = 1'b0;
   endtask

   task automatic wait_valid(output int l1, output int l6);
      l1 = -1; l6 = -1;
      ce = 1'b1; qlen = 4'(QD); retire = 1'b0;
      for (int c = 0; c <= 12; c++) begin
         if (l1 < 0 && if1.valid) l1 = c;
         if (l6 < 0 && if6.valid) l6 = c;
         if (l1 >= 0 && l6 >= 0) break;
         cyc();
      end
   endtask

   task automatic retire_now();
      retire = 1'b1; ce = 1'b1; start = 1'b0;
      cyc();
      retire = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int l1, l6, rem1, rem6, e1, e6, guard, d, i;
      logic [15:0] p;
      logic sx;

      for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
      tbl[0] = '{16'h0100, 3'd2, 3'd2, 1'b0, 48'h0000_5678_1234, 16'h1234, 32'h0000_5678, 16'h0104, 4, 1};
      tbl[1] = '{16'h0200, 3'd0, 3'd1, 1'b1, 48'h80,             16'h0000, 32'hFFFF_FF80, 16'h0201, 1, 1};
      tbl[2] = '{16'h0210, 3'd0, 3'd1, 1'b0, 48'h80,             16'h0000, 32'h0000_0080, 16'h0211, 1, 1};
      tbl[3] = '{16'h0220, 3'd0, 3'd0, 1'b0, 48'h0,              16'h0000, 32'h0000_0000, 16'h0220, 0, 0};
      tbl[4] = '{16'hFFFF, 3'd2, 3'd0, 1'b0, 48'h55AA,           16'h55AA, 32'h0000_0000, 16'h0001, 2, 1};
      tbl[5] = '{16'h0230, 3'd1, 3'd4, 1'b0, 48'h05_0403_0201,   16'h0001, 32'h0504_0302, 16'h0235, 5, 1};
      tbl[6] = '{16'h0240, 3'd2, 3'd1, 1'b1, 48'h7F_FFFE,        16'hFFFE, 32'h0000_007F, 16'h0243, 3, 1};
      tbl[7] = '{16'h0250, 3'd1, 3'd1, 1'b1, 48'hF012,           16'h0012, 32'hFFFF_FFF0, 16'h0252, 2, 1};

      reset = 1'b1; ce = 1'b1; set_pc = 1'b0; new_pc = '0; start = 1'b0;
      disp_size = '0; imm_size = '0; imm_sext = 1'b0; retire = 1'b0; qlen = 4'(QD);
      refresh();
      repeat (3) cyc();
      check("rst_pc", 32'(if1.pc), 32'h0);
      check("rst_disp", 32'(if1.disp), 32'h0);
      check("rst_imm", if6.imm, 32'h0);
      check("rst_end_pc", 32'(if6.end_pc), 32'h0);
      check("rst_flags", {if1.busy, if1.valid, if1.size_err, if1.consumed,
                          if6.busy, if6.valid, if6.size_err, if6.consumed}, 32'h0);
      reset = 1'b0;

      for (int v = 0; v < 8; v++) begin
         load_pc(tbl[v].pc0);
         for (int j = 0; j < int'(tbl[v].d) + int'(tbl[v].i); j++)
            mem[tbl[v].pc0 + 16'(j)] = tbl[v].bytes[8*j +: 8];
         start_txn(tbl[v].d, tbl[v].i, tbl[v].sx);
         wait_valid(l1, l6);
         check($sformatf("v%0d_lat1", v), l1, tbl[v].lat1);
         check($sformatf("v%0d_lat6", v), l6, tbl[v].lat6);
         check($sformatf("v%0d_disp1", v), 32'(if1.disp), 32'(tbl[v].edisp));
         check($sformatf("v%0d_disp6", v), 32'(if6.disp), 32'(tbl[v].edisp));
         check($sformatf("v%0d_imm1", v), if1.imm, tbl[v].eimm);
         check($sformatf("v%0d_imm6", v), if6.imm, tbl[v].eimm);
         check($sformatf("v%0d_end1", v), 32'(if1.end_pc), 32'(tbl[v].eend));
         check($sformatf("v%0d_pc6", v), 32'(if6.pc), 32'(tbl[v].eend));
         retire_now();
         check($sformatf("v%0d_idle", v), {if1.valid, if6.valid}, 32'h0);
      end

      // Queue empties mid-fetch for three cycles.
      load_pc(16'h0300);
      start_txn(3'd2, 3'd2, 1'b0);
      qlen = 4'd0;
      for (int s = 0; s < 3; s++) begin
         #1;
         check("stall_cons", {if1.consumed, if6.consumed}, 32'h0);
         cyc();
         check("stall_pc1", 32'(if1.pc), 32'h0300);
         check("stall_pc6", 32'(if6.pc), 32'h0300);
      end
      qlen = 4'(QD);
      #1;
      check("refill_c1", 32'(if1.consumed), 32'd1);
      check("refill_c6", 32'(if6.consumed), 32'd4);
      wait_valid(l1, l6);
      check("stall_lat1", l1, 4);
      check("stall_disp", 32'(if1.disp), 32'(ref_disp(16'h0300, 2)));
      check("stall_imm", if6.imm, ref_imm(16'h0300, 2, 2, 1'b0));
      retire_now();

      // Flush after one byte; the 6-byte instance is already DONE.
      load_pc(16'h0400);
      start_txn(3'd2, 3'd2, 1'b0);
      cyc();
      set_pc = 1'b1; new_pc = 16'h2000; ce = 1'b0;
      #1;
      check("flush_valid6", 32'(if6.valid), 32'h0);
      check("flush_cons1", 32'(if1.consumed), 32'h0);
      cyc();
      set_pc = 1'b0;
      check("flush_state", {if1.busy, if1.valid, if6.busy, if6.valid}, 32'h0);
      check("flush_pc1", 32'(if1.pc), 32'h2000);
      check("flush_end6", 32'(if6.end_pc), 32'h2000);
      check("flush_disp", {if1.disp, if6.disp}, 32'h0);

      // Out-of-range size.
      check("err_pre", 32'(if1.size_err), 32'h0);
      start_txn(3'd0, 3'd5, 1'b0);
      check("err_set", {if1.size_err, if6.size_err}, 32'h3);
      check("err_idle", {if1.busy, if1.valid, if6.busy, if6.valid}, 32'h0);
      load_pc(16'h0500);
      check("err_sticky", 32'(if6.size_err), 32'h1);

      // Retire without ce, then retire+start back to back.
      start_txn(3'd1, 3'd0, 1'b0);
      wait_valid(l1, l6);
      check("b2b_lat1", l1, 1);
      retire = 1'b1; ce = 1'b0;
      cyc();
      check("retire_noce", {if1.valid, if6.valid}, 32'h3);
      ce = 1'b1; start = 1'b1; disp_size = 3'd0; imm_size = 3'd1; imm_sext = 1'b0;
      cyc();
      start = 1'b0; retire = 1'b0;
      check("b2b_busy", {if1.busy, if6.busy}, 32'h3);
      wait_valid(l1, l6);
      check("b2b_lat", {16'(l1), 16'(l6)}, {16'd1, 16'd1});
      check("b2b_imm", if1.imm, ref_imm(16'h0501, 0, 1, 1'b0));
      retire_now();

      // Randomised transactions with random ce and queue fill.
      for (int t = 0; t < 40; t++) begin
         p = 16'($urandom);
         d = $urandom_range(0, 2);
         i = $urandom_range(0, 4);
         sx = 1'($urandom);
         load_pc(p);
         start_txn(3'(d), 3'(i), sx);
         rem1 = d + i; rem6 = d + i; guard = 0;
         while ((rem1 > 0 || rem6 > 0) && guard < 300) begin
            ce = ($urandom_range(0, 3) != 0);
            qlen = 4'($urandom_range(0, QD));
            #1;
            e1 = ce ? min3(1, rem1, int'(qlen)) : 0;
            e6 = ce ? min3(6, rem6, int'(qlen)) : 0;
            check("rnd_cons1", 32'(if1.consumed), 32'(e1));
            check("rnd_cons6", 32'(if6.consumed), 32'(e6));
            cyc();
            rem1 -= e1; rem6 -= e6; guard++;
         end
         ce = 1'b0;
         check("rnd_bound", guard < 300, 1'b1);
         check("rnd_valid", {if1.valid, if6.valid}, 32'h3);
         check("rnd_disp", {if1.disp, if6.disp}, {2{ref_disp(p, d)}});
         check("rnd_imm1", if1.imm, ref_imm(p, d, i, sx));
         check("rnd_imm6", if6.imm, ref_imm(p, d, i, sx));
         check("rnd_end", {if1.end_pc, if6.end_pc}, {2{p + 16'(d + i)}});
         retire_now();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

`default_nettype wire
